// File: rtl/lane_spawner.sv
// Lane spawner: draws per-lane car settings from a free-running LFSR at the
// start of a round, then arms each lane's SpawnEnable in turn, spaced by a
// programmable number of frame ticks.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for Start; all enables low
// ST_DRAW  | load lane idx settings from the current LFSR value
// ST_SETTLE| settings held one cycle, then raise SpawnEnable[idx]
// ST_WAIT  | count StaggerFrames frame ticks before the next lane
// ST_DONE  | all lanes armed; hold until Clear

`timescale 1ns/1ps

module lane_spawner #(
   parameter int          NumLanes      = 8,
   parameter int          StaggerFrames = 4,
   parameter logic [15:0] Seed          = 16'hACE1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Clear,
   input  logic                  FrameTick,
   output logic [NumLanes-1:0]   SpawnEnable,
   output logic [NumLanes-1:0]   Direction,
   output logic [2*NumLanes-1:0] CarType,
   output logic [3*NumLanes-1:0] CarCount,
   output logic [3*NumLanes-1:0] CarSpeed,
   output logic                  Busy,
   output logic                  Done
);

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [15:0] SEED_EFF  = (Seed == 16'h0000) ? 16'h0001 : Seed;
   localparam int          IW        = (NumLanes < 2) ? 1 : $clog2(NumLanes);
   localparam int          CW        = (StaggerFrames < 2) ? 1 : $clog2(StaggerFrames + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NumLanes - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAW,
      ST_SETTLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [CW-1:0] frame_cnt;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_next;
   logic [2:0]    draw_count;
   logic [2:0]    draw_speed;

   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

   // Fold 0..7 onto 1..5 so a lane never spawns zero cars.
   assign draw_count = (lfsr[6:4] <= 3'd4) ? (lfsr[6:4] + 3'd1) : (lfsr[6:4] - 3'd4);
   assign draw_speed = {1'b0, lfsr[9:8]} + 3'd1;

   // Free-running LFSR; it keeps stepping in every state so the Start timing
   // perturbs which values a round sees.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         lfsr <= SEED_EFF;
      end else begin
         lfsr <= lfsr_next;
      end
   end

   // Sequencer with registered enables, settings and status flags.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         frame_cnt   <= '0;
         SpawnEnable <= '0;
         Direction   <= '0;
         CarType     <= '0;
         CarCount    <= '0;
         CarSpeed    <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
      end else if (Clear) begin
         // Settings buses are left untouched so lanes keep what they captured.
         state       <= ST_IDLE;
         SpawnEnable <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state <= ST_DRAW;
                  idx   <= '0;
                  Busy  <= 1'b1;
               end
            end
            ST_DRAW: begin
               Direction[idx]       <= lfsr[0];
               CarType[2*idx +: 2]  <= lfsr[2:1];
               CarCount[3*idx +: 3] <= draw_count;
               CarSpeed[3*idx +: 3] <= draw_speed;
               state                <= ST_SETTLE;
            end
            ST_SETTLE: begin
               SpawnEnable[idx] <= 1'b1;
               if (idx == LAST_IDX) begin
                  state <= ST_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else if (StaggerFrames == 0) begin
                  state <= ST_DRAW;
                  idx   <= idx + IW'(1);
               end else begin
                  state     <= ST_WAIT;
                  frame_cnt <= CW'(StaggerFrames);
               end
            end
            ST_WAIT: begin
               if (FrameTick) begin
                  if (frame_cnt == CW'(1)) begin
                     state <= ST_DRAW;
                     idx   <= idx + IW'(1);
                  end else begin
                     frame_cnt <= frame_cnt - CW'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lane_spawner.sv
// Bench for lane_spawner: three instances (no stagger, default stagger,
// zero seed) checked cycle by cycle against an edge-schedule model.

`timescale 1ns/1ps

module tb_lane_spawner;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       FrameTick;
   logic [2:0] start_v;
   logic [2:0] clear_v;

   logic [7:0]  en_a, dir_a, en_b, dir_b, en_c, dir_c;
   logic [15:0] typ_a, typ_b, typ_c;
   logic [23:0] cnt_a, cnt_b, cnt_c, spd_a, spd_b, spd_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic        tick_en;
   logic [15:0] m_lfsr, m_lfsr_c, prev_lfsr, prev_lfsr_c;

   logic       e_dir[3][8];
   logic [1:0] e_typ[3][8];
   logic [2:0] e_cnt[3][8];
   logic [2:0] e_spd[3][8];

   always #5 Clk = ~Clk;

   lane_spawner #(.NumLanes(8), .StaggerFrames(0), .Seed(16'hACE1)) dut_a (
      .Clk(Clk), .Reset(Reset), .Start(start_v[0]), .Clear(clear_v[0]), .FrameTick(FrameTick),
      .SpawnEnable(en_a), .Direction(dir_a), .CarType(typ_a), .CarCount(cnt_a),
      .CarSpeed(spd_a), .Busy(busy_a), .Done(done_a));

   lane_spawner #(.NumLanes(8), .StaggerFrames(4), .Seed(16'hACE1)) dut_b (
      .Clk(Clk), .Reset(Reset), .Start(start_v[1]), .Clear(clear_v[1]), .FrameTick(FrameTick),
      .SpawnEnable(en_b), .Direction(dir_b), .CarType(typ_b), .CarCount(cnt_b),
      .CarSpeed(spd_b), .Busy(busy_b), .Done(done_b));

   lane_spawner #(.NumLanes(8), .StaggerFrames(0), .Seed(16'h0000)) dut_c (
      .Clk(Clk), .Reset(Reset), .Start(start_v[2]), .Clear(clear_v[2]), .FrameTick(FrameTick),
      .SpawnEnable(en_c), .Direction(dir_c), .CarType(typ_c), .CarCount(cnt_c),
      .CarSpeed(spd_c), .Busy(busy_c), .Done(done_c));

   function automatic logic [15:0] lfsr_adv(input logic [15:0] r);
      return (r >> 1) ^ (r[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock edge; the reference LFSR follows the rule from the Reset level
   // seen at that edge. prev_* is the value the DUT saw at the edge.
   task automatic step();
      logic rst_seen;
      rst_seen = Reset;
      @(posedge Clk);
      #1;
      cyc++;
      prev_lfsr   = m_lfsr;
      prev_lfsr_c = m_lfsr_c;
      if (!rst_seen) begin
         m_lfsr   = 16'hACE1;
         m_lfsr_c = 16'h0001;
      end else begin
         m_lfsr   = lfsr_adv(m_lfsr);
         m_lfsr_c = lfsr_adv(m_lfsr_c);
      end
      FrameTick = tick_en && (((cyc + 1) % 10) == 0);
   endtask

   task automatic get_obs(input int s, output logic [7:0] en, output logic [7:0] dir,
                          output logic [15:0] typ, output logic [23:0] cnt,
                          output logic [23:0] spd, output logic busy, output logic done);
      case (s)
         0: begin en = en_a; dir = dir_a; typ = typ_a; cnt = cnt_a; spd = spd_a; busy = busy_a; done = done_a; end
         1: begin en = en_b; dir = dir_b; typ = typ_b; cnt = cnt_b; spd = spd_b; busy = busy_b; done = done_b; end
         default: begin en = en_c; dir = dir_c; typ = typ_c; cnt = cnt_c; spd = spd_c; busy = busy_c; done = done_c; end
      endcase
   endtask

   task automatic check_all(input int s, input logic [7:0] xen, input logic xbusy,
                            input logic xdone, input string tag);
      logic [7:0]  en, dir, xdir;
      logic [15:0] typ, xtyp;
      logic [23:0] cnt, spd, xcnt, xspd;
      logic        busy, done;
      get_obs(s, en, dir, typ, cnt, spd, busy, done);
      for (int i = 0; i < 8; i++) begin
         xdir[i]       = e_dir[s][i];
         xtyp[2*i +: 2] = e_typ[s][i];
         xcnt[3*i +: 3] = e_cnt[s][i];
         xspd[3*i +: 3] = e_spd[s][i];
      end
      chk({tag, ".en"},   {24'd0, en},   {24'd0, xen});
      chk({tag, ".dir"},  {24'd0, dir},  {24'd0, xdir});
      chk({tag, ".type"}, {16'd0, typ},  {16'd0, xtyp});
      chk({tag, ".cnt"},  {8'd0, cnt},   {8'd0, xcnt});
      chk({tag, ".spd"},  {8'd0, spd},   {8'd0, xspd});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, xbusy});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, xdone});
   endtask

   task automatic clear_model();
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 8; i++) begin
            e_dir[s][i] = 1'b0; e_typ[s][i] = 2'd0; e_cnt[s][i] = 3'd0; e_spd[s][i] = 3'd0;
         end
   endtask

   // One round on instance s. Lane enable edges are scheduled from the Start
   // edge: +2 for lane 0, then +2 per lane (no stagger) or 2 edges after the
   // stagger-th tick that lands strictly after the previous enable edge.
   // abort_lane >= 0 issues Clear together with Start 3 edges after that lane arms.
   task automatic run_round(input int s, input int stagger, input int abort_lane);
      int          k, t, nt, abort_at, last;
      int          e[8];
      int          c;
      logic [15:0] r;
      logic [7:0]  xen, en, dir;
      logic [15:0] typ;
      logic [23:0] cnt, spd;
      logic        busy, done, aborted, drew;
      int          dl;

      start_v[s] = 1'b1;
      step();
      start_v[s] = 1'b0;
      k = cyc;
      e[0] = k + 2;
      for (int i = 1; i < 8; i++) begin
         if (stagger == 0) begin
            e[i] = e[i-1] + 2;
         end else begin
            t = e[i-1];
            nt = 0;
            while (nt < stagger) begin
               t++;
               if ((t % 10) == 0) nt++;
            end
            e[i] = t + 2;
         end
      end
      abort_at = (abort_lane >= 0) ? e[abort_lane] + 3 : 0;
      last     = (abort_at != 0) ? abort_at + 3 : e[7] + 3;
      check_all(s, 8'h00, 1'b1, 1'b0, "start");

      while (cyc < last) begin
         if (abort_at != 0 && cyc + 1 == abort_at) begin
            clear_v[s] = 1'b1;
            start_v[s] = 1'b1;
         end else if (abort_at == 0 && cyc + 1 == e[7] + 2) begin
            start_v[s] = 1'b1;
         end
         step();
         clear_v[s] = 1'b0;
         start_v[s] = 1'b0;
         r = (s == 2) ? prev_lfsr_c : prev_lfsr;
         aborted = (abort_at != 0) && (cyc >= abort_at);
         drew = 1'b0;
         dl = 0;
         xen = 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (!aborted && cyc == e[i] - 1) begin
               c = int'(r[6:4]);
               e_dir[s][i] = r[0];
               e_typ[s][i] = r[2:1];
               e_cnt[s][i] = (c <= 4) ? 3'(c + 1) : 3'(c - 4);
               e_spd[s][i] = 3'(int'(r[9:8]) + 1);
               drew = 1'b1;
               dl = i;
            end
            if (!aborted && cyc >= e[i]) xen[i] = 1'b1;
         end
         check_all(s, xen, !aborted && (cyc < e[7]), !aborted && (cyc >= e[7]), "cyc");
         if (drew) begin
            get_obs(s, en, dir, typ, cnt, spd, busy, done);
            chk("cnt_range", {31'd0, (cnt[3*dl +: 3] >= 3'd1) && (cnt[3*dl +: 3] <= 3'd5)}, 32'd1);
            chk("spd_range", {31'd0, (spd[3*dl +: 3] >= 3'd1) && (spd[3*dl +: 3] <= 3'd4)}, 32'd1);
            if (r[6:4] == 3'b111) chk("cnt_fold7", {29'd0, cnt[3*dl +: 3]}, 32'd3);
            if (r[9:8] == 2'b11)  chk("spd_max",   {29'd0, spd[3*dl +: 3]}, 32'd4);
         end
      end

      if (abort_at == 0) begin
         clear_v[s] = 1'b1;
         step();
         clear_v[s] = 1'b0;
         check_all(s, 8'h00, 1'b0, 1'b0, "clear");
      end
   endtask

   initial begin
      Reset     = 1'b0;
      start_v   = '0;
      clear_v   = '0;
      FrameTick = 1'b0;
      tick_en   = 1'b1;
      m_lfsr    = 16'hACE1;
      m_lfsr_c  = 16'h0001;
      clear_model();

      step();
      step();
      for (int s = 0; s < 3; s++) check_all(s, 8'h00, 1'b0, 1'b0, "reset");
      chk("lfsr_a_rst", {16'd0, dut_a.lfsr}, 32'h0000ACE1);
      chk("lfsr_c_rst", {16'd0, dut_c.lfsr}, 32'h00000001);
      Reset = 1'b1;
      step();
      chk("lfsr_c_step", {16'd0, dut_c.lfsr}, 32'h0000B400);
      chk("lfsr_a_step", {16'd0, dut_a.lfsr}, {16'd0, m_lfsr});

      run_round(0, 0, -1);
      run_round(2, 0, -1);
      run_round(1, 4, -1);
      run_round(1, 4, 3);
      repeat (4) step();
      check_all(1, 8'h00, 1'b0, 1'b0, "after_abort");
      run_round(1, 4, -1);

      repeat (1000) begin
         repeat ($urandom_range(0, 6)) step();
         run_round(0, 0, -1);
      end
      repeat (2) begin
         repeat ($urandom_range(0, 9)) step();
         run_round(1, 4, -1);
      end

      // Reset in the middle of a staggered wait.
      start_v[1] = 1'b1;
      step();
      start_v[1] = 1'b0;
      repeat (5) step();
      chk("wait_busy", {31'd0, busy_b}, 32'd1);
      Reset = 1'b0;
      step();
      step();
      clear_model();
      for (int s = 0; s < 3; s++) check_all(s, 8'h00, 1'b0, 1'b0, "mid_reset");
      chk("lfsr_b_rst", {16'd0, dut_b.lfsr}, 32'h0000ACE1);
      Reset = 1'b1;
      step();
      check_all(1, 8'h00, 1'b0, 1'b0, "post_reset");
      chk("lfsr_b_model", {16'd0, dut_b.lfsr}, {16'd0, m_lfsr});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
